local_inport_buffer: RTL
========================

Name: local_inport_buffer

Overview:
- Router-side local input port. Directly downstream of the processor element: consumes its 20-bit flit stream (dataout/out_valid).
- Returns one credit per freed slot on credit_out, which connects to the PE's ci.
- Buffers flits in a DEPTH-entry FIFO, computes the XY output port for the head flit, and presents it to the crossbar with a request/grant handshake.

Parameters:
- DATA_W, 20, flit width
- DEPTH, 4, FIFO entries; must equal the PE's credit count (4)
- MY_X, 0, this router's X coordinate (0..3)
- MY_Y, 0, this router's Y coordinate (0..3)

Ports:
- clk  in  1  clock, all logic on posedge
- RST  in  1  reset, synchronous, active-high
- flit_in  in  DATA_W  flit from PE; [19:18]=dest X, [17:16]=dest Y, [15:0]=payload
- flit_in_valid  in  1  flit_in valid this cycle
- credit_out  out  1  one-cycle pulse per slot freed (to PE ci)
- flit_out  out  DATA_W  head flit to crossbar
- flit_out_valid  out  1  FIFO non-empty
- req  out  5  one-hot output request {L,W,E,S,N} = bits {4,3,2,1,0}
- grant  in  1  crossbar accepts head flit this cycle
- overflow  out  1  sticky error: push attempted while full with no pop

Behaviour:
- Reset (RST=1 at posedge): rd/wr pointers=0, count=0, credit_out=0, overflow=0, flit_out_valid=0, req=0. FIFO contents are don't-care. Applies mid-operation: buffered flits are discarded and no credits are returned for them.
- Push: flit_in_valid=1 and (count<DEPTH or pop this cycle) -> write at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
- Pop: grant=1 and count>0 -> rd_ptr advances with wrap. grant while empty is ignored: no pop, no credit.
- count update: push only +1; pop only -1; push and pop together unchanged. This includes full (write into the slot being freed) and empty (flit enters the FIFO, not bypassed).
- Overflow: flit_in_valid=1, count==DEPTH, no pop -> flit dropped, overflow<=1. Held until reset.
- Latency: a flit pushed at edge N appears on flit_out/req after edge N when the FIFO was empty. Minimum flit_in to flit_out latency is 1 cycle.
- flit_out = mem[rd_ptr]; flit_out_valid = (count!=0); both registered-state driven, no combinational path from flit_in.
- req is combinational from the head flit, 0 when empty. With dx=flit_out[19:18], dy=flit_out[17:16]:
  - dx>MY_X -> E (bit2); dx<MY_X -> W (bit3);
  - else dy>MY_Y -> N (bit0); dy<MY_Y -> S (bit1);
  - else L (bit4).
  - Exactly one bit set when valid.
- grant is legal only when req!=0. Crossbar holds grant low while flit_out_valid=0.
- credit_out: registered; credit_out<=1 in the cycle after each pop edge, else 0. Back-to-back pops give back-to-back pulses. Total credits returned never exceed total flits accepted.
- Width rules: pointers $clog2(DEPTH) bits; count $clog2(DEPTH)+1 bits.

Optional Feature:
- Macro INPORT_FLIT_CNT_EN. When defined, adds output port fwd_cnt[15:0]: counts pops, reset to 0, wraps 16'hFFFF -> 0, +1 on each pop edge.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: RST=1 two cycles, release -> flit_out_valid=0, req=5'b00000, credit_out=0, overflow=0 for 10 cycles.
- Routing, MY_X=1, MY_Y=2, grant tied 1, one flit each:
  - dest (3,2) -> req=5'b00100
  - dest (0,2) -> 5'b01000
  - dest (1,3) -> 5'b00001
  - dest (1,0) -> 5'b00010
  - dest (1,2) -> 5'b10000
  - Each flit: credit_out pulse 2 cycles after flit_in_valid edge.
- Fill/credit, grant=0: push payloads 16'h0001..16'h0004 -> count=4, no credit pulses. Then grant=1 for 4 cycles -> flit_out 0001,0002,0003,0004 in order, 4 consecutive credit_out pulses, flit_out_valid=0 after.
- Full with simultaneous push/pop: 4 flits buffered, then flit_in_valid=1 (payload 16'h0005) and grant=1 same cycle -> count stays 4, overflow=0; 0005 emerges fifth.
- Overflow: 4 flits buffered, grant=0, push 16'h00FF -> overflow=1 and remains 1. Drain yields only the original 4 flits, 4 credits. RST clears overflow.
- Reset mid-stream: 3 flits buffered, assert RST one cycle -> flit_out_valid=0, no credit pulses afterwards. New flit after release routes normally. With INPORT_FLIT_CNT_EN, fwd_cnt=0 after reset and equals 3 after 3 pops.

Source files
------------

// File: rtl/local_inport_buffer.sv
`default_nettype none
// ============================================================================
// Module   : local_inport_buffer
// Purpose  : Router local input port. It buffers flits from the PE in a FIFO,
//            routes the head flit by XY order, and returns one credit per pop.
//            Optional INPORT_FLIT_CNT_EN adds the fwd_cnt pop counter.
// Revision : 1.0  initial release
// ============================================================================
module local_inport_buffer #(
   parameter int DATA_W = 20,
   parameter int DEPTH  = 4,
   parameter int MY_X   = 0,
   parameter int MY_Y   = 0
) (
   input  logic              clk,
   input  logic              RST,
   input  logic [DATA_W-1:0] flit_in,
   input  logic              flit_in_valid,
   output logic              credit_out,
   output logic [DATA_W-1:0] flit_out,
   output logic              flit_out_valid,
   output logic [4:0]        req,
   input  logic              grant,
`ifdef INPORT_FLIT_CNT_EN
   output logic [15:0]       fwd_cnt,
`endif
   output logic              overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [1:0]       X_COORD  = 2'(MY_X);
   localparam logic [1:0]       Y_COORD  = 2'(MY_Y);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              pop;
   logic              push;
   logic              full;
   logic [1:0]        dx;
   logic [1:0]        dy;

   assign full = (count == FULL_CNT);
   assign pop  = grant && (count != '0);
   // A full FIFO still accepts a flit when the head leaves in the same cycle.
   assign push = flit_in_valid && (!full || pop);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= flit_in;
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         credit_out <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         credit_out <= pop;
         if (push) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         if (flit_in_valid && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

`ifdef INPORT_FLIT_CNT_EN
   always_ff @(posedge clk) begin
      if (RST) begin
         fwd_cnt <= '0;
      end else if (pop) begin
         fwd_cnt <= fwd_cnt + 16'd1;
      end
   end
`endif

   assign flit_out       = mem[rd_ptr];
   assign flit_out_valid = (count != '0);
   assign dx             = flit_out[DATA_W-1 -: 2];
   assign dy             = flit_out[DATA_W-3 -: 2];

   // XY routing: resolve X first, then Y, else eject locally.
   always_comb begin
      req = 5'b00000;
      if (flit_out_valid) begin
         if (dx > X_COORD) begin
            req = 5'b00100;
         end else if (dx < X_COORD) begin
            req = 5'b01000;
         end else if (dy > Y_COORD) begin
            req = 5'b00001;
         end else if (dy < Y_COORD) begin
            req = 5'b00010;
         end else begin
            req = 5'b10000;
         end
      end
   end

endmodule
`default_nettype wire
